// File: rtl/rf_writeback_ctrl.sv
// Register-file write-port controller: merges the ALU and memory result paths,
// buffers memory results in a small FIFO and tracks per-register pending writes.
module rf_writeback_ctrl #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       issue_valid,
  input  logic [4:0]                 issue_rd,
  input  logic                       alu_valid,
  input  logic [4:0]                 alu_rd,
  input  logic [XLEN-1:0]            alu_data,
  input  logic                       mem_valid,
  output logic                       mem_ready,
  input  logic [4:0]                 mem_rd,
  input  logic [XLEN-1:0]            mem_data,
  output logic                       rf_we,
  output logic [4:0]                 rf_waddr,
  output logic [XLEN-1:0]            rf_wdata,
  input  logic [4:0]                 rs1,
  input  logic [4:0]                 rs2,
  output logic                       rs1_pending,
  output logic                       rs2_pending,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FullCount = CW'(DEPTH);

  logic [4:0]      fifo_rd   [DEPTH];
  logic [XLEN-1:0] fifo_data [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic [31:0]     pending_q, pending_d;

  logic            rf_we_q, rf_we_d;
  logic [4:0]      rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;

  logic full, empty, alu_wr, push, pop;

  assign full      = (count_q == FullCount);
  assign empty     = (count_q == '0);
  assign mem_ready = !full;
  // A zero destination completes the handshake but is never stored.
  assign push      = mem_valid && !full && (mem_rd != 5'd0);
  // ALU writes to x0 are dropped and must not block the FIFO.
  assign alu_wr    = alu_valid && (alu_rd != 5'd0);
  assign pop       = !alu_wr && !empty;

  // Next-state for FIFO pointers/count and the registered write port.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (alu_wr) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = alu_rd;
      rf_wdata_d = alu_data;
    end else if (pop) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = fifo_rd[rd_ptr_q];
      rf_wdata_d = fifo_data[rd_ptr_q];
    end
  end

  // Scoreboard update: clear on the write leaving rf_*, then set on issue so set wins.
  always_comb begin
    pending_d = pending_q;
    if (rf_we_q) pending_d[rf_waddr_q] = 1'b0;
    if (issue_valid && (issue_rd != 5'd0)) pending_d[issue_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  // Control state with asynchronous reset; in-flight writes are discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      pending_q  <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      pending_q  <= pending_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  // FIFO storage; validity is tracked by the pointers, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr_q]   <= mem_rd;
      fifo_data[wr_ptr_q] <= mem_data;
    end
  end

  assign rf_we       = rf_we_q;
  assign rf_waddr    = rf_waddr_q;
  assign rf_wdata    = rf_wdata_q;
  assign fifo_count  = count_q;
  assign rs1_pending = pending_q[rs1];
  assign rs2_pending = pending_q[rs2];

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Directed bench for rf_writeback_ctrl: linear steps with immediate-assertion checks.
module tb_rf_writeback_ctrl;

  logic        clk, rst;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        mem_valid, mem_ready;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  rs1, rs2;
  logic        rs1_pending, rs2_pending;
  logic [2:0]  fifo_count;

  int vectors = 0;
  int errs    = 0;

  rf_writeback_ctrl #(.XLEN(32), .DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .mem_rd      (mem_rd),
    .mem_data    (mem_data),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .rs1         (rs1),
    .rs2         (rs2),
    .rs1_pending (rs1_pending),
    .rs2_pending (rs2_pending),
    .fifo_count  (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 2 time units later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    issue_valid = 1'b0; issue_rd = '0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
  endtask

  initial begin
    idle();
    rs1 = '0; rs2 = '0;
    rst = 1'b1;
    #12;
    chk("rst_we", 32'(rf_we), 32'd0);
    chk("rst_waddr", 32'(rf_waddr), 32'd0);
    chk("rst_wdata", rf_wdata, 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_ready", 32'(mem_ready), 32'd1);
    @(posedge clk); #1 rst = 1'b0;
    tick();

    // ALU write with scoreboard clear one edge later
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    idle();
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'hDEADBEEF; rs1 = 5'd7;
    #1 chk("alu_pend_set", 32'(rs1_pending), 32'd1);
    tick();
    chk("alu_we", 32'(rf_we), 32'd1);
    chk("alu_waddr", 32'(rf_waddr), 32'd7);
    chk("alu_wdata", rf_wdata, 32'hDEADBEEF);
    chk("alu_pend_hold", 32'(rs1_pending), 32'd1);
    idle();
    tick();
    chk("alu_pend_clr", 32'(rs1_pending), 32'd0);
    chk("alu_we_drop", 32'(rf_we), 32'd0);
    chk("alu_waddr_hold", 32'(rf_waddr), 32'd7);
    chk("alu_wdata_hold", rf_wdata, 32'hDEADBEEF);

    // ALU priority over a waiting FIFO entry
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hAA;
    mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'h11;
    tick();
    chk("pri_count1", 32'(fifo_count), 32'd1);
    mem_valid = 1'b0; alu_rd = 5'd4; alu_data = 32'h22;
    tick();
    chk("pri_alu_addr", 32'(rf_waddr), 32'd4);
    chk("pri_alu_data", rf_wdata, 32'h22);
    chk("pri_count_keep", 32'(fifo_count), 32'd1);
    idle();
    tick();
    chk("pri_mem_we", 32'(rf_we), 32'd1);
    chk("pri_mem_addr", 32'(rf_waddr), 32'd3);
    chk("pri_mem_data", rf_wdata, 32'h11);
    chk("pri_count0", 32'(fifo_count), 32'd0);

    // Fill under sustained ALU traffic, then drain in order
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1;
    for (int i = 0; i < 4; i++) begin
      mem_valid = 1'b1; mem_rd = 5'(10 + i); mem_data = 32'h100 + 32'(i);
      chk("fill_ready", 32'(mem_ready), 32'd1);
      tick();
    end
    chk("full_count", 32'(fifo_count), 32'd4);
    chk("full_ready", 32'(mem_ready), 32'd0);
    mem_rd = 5'd14; mem_data = 32'h104;
    tick();
    chk("full_hold_count", 32'(fifo_count), 32'd4);
    chk("full_hold_ready", 32'(mem_ready), 32'd0);
    alu_valid = 1'b0;
    tick();
    chk("drain0_addr", 32'(rf_waddr), 32'd10);
    chk("drain0_data", rf_wdata, 32'h100);
    chk("drain0_count", 32'(fifo_count), 32'd3);
    chk("drain0_ready", 32'(mem_ready), 32'd1);
    tick();
    chk("drain1_addr", 32'(rf_waddr), 32'd11);
    chk("drain1_data", rf_wdata, 32'h101);
    chk("drain1_count", 32'(fifo_count), 32'd3);
    idle();
    for (int i = 2; i < 5; i++) begin
      tick();
      chk("drain_we", 32'(rf_we), 32'd1);
      chk("drain_addr", 32'(rf_waddr), 32'(10 + i));
      chk("drain_data", rf_wdata, 32'h100 + 32'(i));
      chk("drain_count", 32'(fifo_count), 32'(4 - i));
    end
    tick();
    chk("drain_idle_we", 32'(rf_we), 32'd0);
    chk("drain_ready", 32'(mem_ready), 32'd1);

    // x0 filtering on all three paths
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1;
    mem_valid = 1'b1; mem_rd = 5'd20; mem_data = 32'h55;
    tick();
    chk("x0_setup_count", 32'(fifo_count), 32'd1);
    alu_rd = 5'd0; alu_data = 32'h99;
    mem_rd = 5'd0; mem_data = 32'h77;
    chk("x0_mem_ready", 32'(mem_ready), 32'd1);
    tick();
    chk("x0_pop_addr", 32'(rf_waddr), 32'd20);
    chk("x0_pop_data", rf_wdata, 32'h55);
    chk("x0_count", 32'(fifo_count), 32'd0);
    idle();
    issue_valid = 1'b1; issue_rd = 5'd0;
    tick();
    idle();
    rs1 = 5'd0;
    #1 chk("x0_pending", 32'(rs1_pending), 32'd0);
    chk("x0_alu_no_write", 32'(rf_we), 32'd0);

    // Set/clear collision on x9: set wins
    issue_valid = 1'b1; issue_rd = 5'd9;
    tick();
    idle();
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h9;
    tick();
    idle();
    chk("col_we", 32'(rf_we), 32'd1);
    issue_valid = 1'b1; issue_rd = 5'd9;
    tick();
    idle();
    rs2 = 5'd9;
    #1 chk("col_pending", 32'(rs2_pending), 32'd1);
    tick();
    chk("col_pending_hold", 32'(rs2_pending), 32'd1);

    // Asynchronous reset mid-stream
    issue_valid = 1'b1; issue_rd = 5'd5;
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1;
    mem_valid = 1'b1; mem_rd = 5'd21; mem_data = 32'h21;
    tick();
    issue_valid = 1'b0; mem_rd = 5'd22;
    tick();
    mem_rd = 5'd23;
    tick();
    mem_valid = 1'b0;
    rs1 = 5'd5;
    #1 chk("pre_rst_count", 32'(fifo_count), 32'd3);
    chk("pre_rst_pend", 32'(rs1_pending), 32'd1);
    chk("pre_rst_we", 32'(rf_we), 32'd1);
    rst = 1'b1;
    #1 chk("arst_we", 32'(rf_we), 32'd0);
    chk("arst_count", 32'(fifo_count), 32'd0);
    chk("arst_pend", 32'(rs1_pending), 32'd0);
    chk("arst_ready", 32'(mem_ready), 32'd1);
    idle();
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_we", 32'(rf_we), 32'd0);
    chk("post_rst_count", 32'(fifo_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
